// File: rtl/apb_pkg.sv
// Shared APB definitions: one-hot master FSM encodings and default bus widths.
// Also used by the APB slave side, so encodings stay fixed.
package apb_pkg;

   localparam logic [2:0] APB_IDLE   = 3'b001;
   localparam logic [2:0] APB_SETUP  = 3'b010;
   localparam logic [2:0] APB_ACCESS = 3'b100;

   localparam int unsigned APB_ADDR_W = 12;
   localparam int unsigned APB_DATA_W = 32;

endpackage

// File: rtl/apb_master_bridge_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers and full/empty flags.
// A push while full and a pop while empty are both ignored.
module cmd_fifo #(
   parameter int unsigned WIDTH = 45,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/apb_master_bridge.sv
// Buffered command-to-APB master: queues commands, replays each as SETUP/ACCESS,
// returns one response per command and force-completes hung transfers with an error.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W     = APB_ADDR_W,
   parameter int unsigned DATA_W     = APB_DATA_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata,
   output logic              busy
);

   localparam int unsigned     CMD_W    = 1 + ADDR_W + DATA_W;
   localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic              fifo_full, fifo_empty, fifo_pop;
   logic [CMD_W-1:0]  head;
   logic              head_write;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_wdata;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              go_idle;

   assign cmd_ready = !fifo_full && !prst;
   assign {head_write, head_addr, head_wdata} = head;

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (pclk),
      .rst   (prst),
      .push  (cmd_valid && cmd_ready),
      .wdata ({cmd_write, cmd_addr, cmd_wdata}),
      .pop   (fifo_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      fifo_pop    = 1'b0;
      go_idle     = 1'b0;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         APB_IDLE: begin
            // Only issue once the response slot is free (or freeing on this edge).
            if (!fifo_empty && (!rsp_valid_q || rsp_ready)) begin
               fifo_pop  = 1'b1;
               state_d   = APB_SETUP;
               cnt_d     = '0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = head_write;
               paddr_d   = head_addr;
               pwdata_d  = head_write ? head_wdata : '0;
            end
         end
         APB_SETUP: begin
            state_d   = APB_ACCESS;
            penable_d = 1'b1;
         end
         APB_ACCESS: begin
            if (pready) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = pwrite_q ? '0 : prdata;
               go_idle     = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               go_idle     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (go_idle) begin
         state_d   = APB_IDLE;
         psel_d    = 1'b0;
         penable_d = 1'b0;
         pwrite_d  = 1'b0;
         paddr_d   = '0;
         pwdata_d  = '0;
      end
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q     <= APB_IDLE;
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = !fifo_empty || (state_q != APB_IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: SRAM-like APB slave stub with programmable wait states,
// scoreboard of expected responses, table-driven traffic plus multi-cycle corner sequences.
module tb_apb_master_bridge;

   logic        pclk = 1'b0;
   logic        prst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        busy;

   always #5 pclk = ~pclk;

   apb_master_bridge #(
      .ADDR_W     (12),
      .DATA_W     (32),
      .FIFO_DEPTH (4),
      .TIMEOUT    (16)
   ) dut (
      .pclk      (pclk),
      .prst      (prst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pready    (pready),
      .prdata    (prdata),
      .busy      (busy)
   );

   // Slave stub: word SRAM; garbage on prdata while stalling so early capture is visible.
   logic [31:0] smem [1024];
   int unsigned wait_cnt = 0;
   int unsigned slave_wait = 0;
   bit          slave_hang = 1'b0;

   assign pready = penable && !slave_hang && (wait_cnt >= slave_wait);
   assign prdata = pready ? smem[paddr[11:2]] : (32'hBAD0_0000 | wait_cnt);

   always @(posedge pclk) begin
      if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
      else                            wait_cnt <= 0;
      if (psel && penable && pready && pwrite) smem[paddr[11:2]] <= pwdata;
   end

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic        w;
      logic [11:0] a;
      logic [31:0] d;
      logic        e_err;
      logic [31:0] e_rd;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every consumed response is matched in order against the scoreboard.
   always @(negedge pclk) begin
      exp_t e;
      if (!prst && rsp_valid && rsp_ready) begin
         chk("rsp_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   task automatic try_send(input logic w, input logic [11:0] a, input logic [31:0] d,
                           input logic e_err, input logic [31:0] e_rd,
                           input bit push_sb, input int limit, output bit acc);
      exp_t e;
      e.err   = e_err;
      e.rdata = e_rd;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      acc = 1'b0;
      for (int n = 0; n < limit; n++) begin
         @(negedge pclk);
         if (cmd_ready) begin
            acc = 1'b1;
            break;
         end
      end
      if (acc) begin
         @(posedge pclk);
         if (push_sb) sb.push_back(e);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd);
      bit acc;
      try_send(w, a, d, e_err, e_rd, 1'b1, 20, acc);
      chk("cmd_accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      @(negedge pclk);
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge pclk);
         n++;
      end
      chk(name, 32'(n < 200), 32'd1);
   endtask

   task automatic latency(input string name);
      int k = 0;
      while (!rsp_valid && k < 20) begin
         @(posedge pclk);
         #1;
         k++;
      end
      chk(name, 32'(k), 32'd3);
   endtask

   // Counts ACCESS cycles of the next transfer and checks bus stability throughout.
   task automatic measure_access(input logic [11:0] a, input logic [31:0] d, input logic w,
                                 output int cnt, output bit stable);
      int n = 0;
      cnt    = 0;
      stable = 1'b1;
      @(negedge pclk);
      while (!penable && n < 20) begin
         @(negedge pclk);
         n++;
      end
      while (penable && cnt < 60) begin
         if (!psel || paddr !== a || pwdata !== d || pwrite !== w) stable = 1'b0;
         cnt++;
         @(negedge pclk);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      vec_t v2[6];
      bit   acc;
      int   acc_cnt;
      int   cnt;
      bit   stable;
      bit   psel_seen;

      vt[0] = '{1'b1, 12'h000, 32'h1111_1111, 1'b0, 32'h0};
      vt[1] = '{1'b1, 12'hFFC, 32'hCAFE_F00D, 1'b0, 32'h0};
      vt[2] = '{1'b0, 12'h000, 32'h0,         1'b0, 32'h1111_1111};
      vt[3] = '{1'b0, 12'hFFC, 32'h0,         1'b0, 32'hCAFE_F00D};
      vt[4] = '{1'b0, 12'h004, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vt[5] = '{1'b1, 12'h008, 32'h0BAD_F00D, 1'b0, 32'h0};

      v2[0] = '{1'b1, 12'h100, 32'hA1A1_A1A1, 1'b0, 32'h0};
      v2[1] = '{1'b1, 12'h104, 32'hA2A2_A2A2, 1'b0, 32'h0};
      v2[2] = '{1'b0, 12'h104, 32'h0,         1'b0, 32'hA2A2_A2A2};
      v2[3] = '{1'b0, 12'h100, 32'h0,         1'b0, 32'hA1A1_A1A1};
      v2[4] = '{1'b1, 12'h108, 32'hA3A3_A3A3, 1'b0, 32'h0};
      v2[5] = '{1'b0, 12'h108, 32'h0,         1'b0, 32'hA3A3_A3A3};

      prst = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_psel",      32'(psel),      32'd0);
      chk("rst_penable",   32'(penable),   32'd0);
      chk("rst_paddr",     32'(paddr),     32'd0);
      chk("rst_pwdata",    pwdata,         32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      prst = 1'b0;
      @(posedge pclk);
      #1;

      // Write then read with zero-wait slave, checking accept-to-response latency
      send(1'b1, 12'h004, 32'hDEAD_BEEF, 1'b0, 32'h0);
      latency("lat_write");
      wait_drain("drain_t1w");
      @(posedge pclk);
      #1;
      send(1'b0, 12'h004, 32'h0, 1'b0, 32'hDEAD_BEEF);
      latency("lat_read");
      wait_drain("drain_t1r");

      // Table traffic back-to-back: address 0x000 / 0xFFC edges
      @(posedge pclk);
      #1;
      for (int i = 0; i < 6; i++) send(vt[i].w, vt[i].a, vt[i].d, vt[i].e_err, vt[i].e_rd);
      wait_drain("drain_table");

      // Backpressure: 1 issued + 4 queued, sixth refused, bus idle while blocked
      @(posedge pclk);
      #1;
      rsp_ready = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         try_send(v2[i].w, v2[i].a, v2[i].d, v2[i].e_err, v2[i].e_rd, 1'b1, 8, acc);
         acc_cnt += int'(acc);
      end
      psel_seen = 1'b0;
      repeat (5) begin
         @(negedge pclk);
         psel_seen |= psel;
      end
      chk("bp_accepted",  32'(acc_cnt),   32'd5);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_psel_idle", 32'(psel_seen), 32'd0);
      chk("bp_rsp_held",  32'(rsp_valid), 32'd1);
      chk("bp_busy",      32'(busy),      32'd1);
      rsp_ready = 1'b1;
      wait_drain("drain_bp");

      // Wait states: 3 stall cycles -> 4 ACCESS cycles, bus stable
      slave_wait = 3;
      @(posedge pclk);
      #1;
      send(1'b1, 12'h200, 32'h5A5A_1234, 1'b0, 32'h0);
      measure_access(12'h200, 32'h5A5A_1234, 1'b1, cnt, stable);
      chk("ws_wr_cycles", 32'(cnt),    32'd4);
      chk("ws_wr_stable", 32'(stable), 32'd1);
      wait_drain("drain_ws_wr");
      @(posedge pclk);
      #1;
      send(1'b0, 12'h200, 32'h0, 1'b0, 32'h5A5A_1234);
      measure_access(12'h200, 32'h0, 1'b0, cnt, stable);
      chk("ws_rd_cycles", 32'(cnt),    32'd4);
      chk("ws_rd_stable", 32'(stable), 32'd1);
      wait_drain("drain_ws_rd");
      slave_wait = 0;

      // Timeout on a hung slave, next queued command completes normally
      slave_hang = 1'b1;
      @(posedge pclk);
      #1;
      send(1'b0, 12'h100, 32'h0, 1'b1, 32'h0);
      send(1'b0, 12'h104, 32'h0, 1'b0, 32'hA2A2_A2A2);
      measure_access(12'h100, 32'h0, 1'b0, cnt, stable);
      chk("to_cycles",    32'(cnt),       32'd16);
      chk("to_stable",    32'(stable),    32'd1);
      chk("to_psel_low",  32'(psel),      32'd0);
      chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("to_rsp_err",   32'(rsp_err),   32'd1);
      slave_hang = 1'b0;
      wait_drain("drain_to");

      // Reset during ACCESS with two queued commands: everything discarded
      slave_hang = 1'b1;
      @(posedge pclk);
      #1;
      try_send(1'b0, 12'h100, 32'h0, 1'b0, 32'h0, 1'b0, 20, acc);
      try_send(1'b0, 12'h104, 32'h0, 1'b0, 32'h0, 1'b0, 20, acc);
      try_send(1'b0, 12'h108, 32'h0, 1'b0, 32'h0, 1'b0, 20, acc);
      cnt = 0;
      while (!penable && cnt < 20) begin
         @(negedge pclk);
         cnt++;
      end
      chk("mr_in_access", 32'(penable), 32'd1);
      @(posedge pclk);
      #1;
      prst = 1'b1;
      @(posedge pclk);
      #1;
      chk("mr_psel",      32'(psel),      32'd0);
      chk("mr_penable",   32'(penable),   32'd0);
      chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mr_busy",      32'(busy),      32'd0);
      chk("mr_cmd_ready", 32'(cmd_ready), 32'd0);
      prst = 1'b0;
      slave_hang = 1'b0;
      repeat (20) @(posedge pclk);
      #1;
      chk("mr_quiet_busy", 32'(busy),      32'd0);
      chk("mr_quiet_rsp",  32'(rsp_valid), 32'd0);
      chk("mr_quiet_psel", 32'(psel),      32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
